// File: rtl/err_compute_sat.sv
// Position-weighted IR error: eight terms accumulated serially through one shared
// add/subtract datapath, then clipped to a signed ERR_W-bit result with a one-cycle strobe.
module err_compute_sat #(
    parameter int IR_W  = 12,
    parameter int ERR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    IR_vld,
    input  logic [IR_W-1:0]         IR_R0,
    input  logic [IR_W-1:0]         IR_R1,
    input  logic [IR_W-1:0]         IR_R2,
    input  logic [IR_W-1:0]         IR_R3,
    input  logic [IR_W-1:0]         IR_L0,
    input  logic [IR_W-1:0]         IR_L1,
    input  logic [IR_W-1:0]         IR_L2,
    input  logic [IR_W-1:0]         IR_L3,
    output logic signed [ERR_W-1:0] err_sat,
    output logic                    err_vld,
    output logic                    busy
);

    // Largest weighted sum is 15*(2^IR_W-1), so five extra bits never wrap.
    localparam int ACC_W = IR_W + 5;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(2 ** (ERR_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(2 ** (ERR_W - 1)));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] term;
    logic [IR_W-1:0]         r_cap [4];
    logic [IR_W-1:0]         l_cap [4];
    logic [IR_W-1:0]         sel;
    logic                    start;

    function automatic logic signed [ERR_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > ACC_MAX)
            sat = {1'b0, {(ERR_W-1){1'b1}}};
        else if (a < ACC_MIN)
            sat = {1'b1, {(ERR_W-1){1'b0}}};
        else
            sat = a[ERR_W-1:0];
    endfunction

    assign start = (state == IDLE) && IR_vld;
    assign busy  = (state == ACCUM) || (state == SAT);

    // Even cnt adds a right reading, odd cnt subtracts a left one; weight is 2^(cnt/2).
    assign sel  = cnt[0] ? l_cap[cnt[2:1]] : r_cap[cnt[2:1]];
    assign term = $signed({{(ACC_W-IR_W){1'b0}}, sel} << cnt[2:1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = IR_vld ? ACCUM : IDLE;
            ACCUM:   state_nxt = (cnt == 3'd7) ? SAT : ACCUM;
            SAT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame capture: readings only need to be valid at the accepting edge.
    always_ff @(posedge clk) begin
        if (start) begin
            r_cap[0] <= IR_R0;
            r_cap[1] <= IR_R1;
            r_cap[2] <= IR_R2;
            r_cap[3] <= IR_R3;
            l_cap[0] <= IR_L0;
            l_cap[1] <= IR_L1;
            l_cap[2] <= IR_L2;
            l_cap[3] <= IR_L3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            err_sat <= '0;
            err_vld <= 1'b0;
        end else begin
            err_vld <= (state == SAT);
            if (start) begin
                acc <= '0;
                cnt <= '0;
            end else if (state == ACCUM) begin
                acc <= cnt[0] ? (acc - term) : (acc + term);
                cnt <= cnt + 3'd1;
            end
            if (state == SAT)
                err_sat <= sat(acc);
        end
    end

endmodule

// File: tb/tb_err_compute_sat.sv
// Directed bench for err_compute_sat: table of frames with hand-computed errors,
// plus sequences for hold, ignored re-pulses and mid-frame reset.
module tb_err_compute_sat;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        IR_vld;
    logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3;
    logic [11:0] IR_L0, IR_L1, IR_L2, IR_L3;
    logic [9:0]  err_sat;
    logic        err_vld;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string            name;
        logic [3:0][11:0] r;
        logic [3:0][11:0] l;
        logic [9:0]       exp;
    } vec_t;

    vec_t vecs[11];

    err_compute_sat #(.IR_W(12), .ERR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .IR_vld(IR_vld),
        .IR_R0(IR_R0), .IR_R1(IR_R1), .IR_R2(IR_R2), .IR_R3(IR_R3),
        .IR_L0(IR_L0), .IR_L1(IR_L1), .IR_L2(IR_L2), .IR_L3(IR_L3),
        .err_sat(err_sat), .err_vld(err_vld), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input int r0, input int r1, input int r2,
                                input int r3, input int l0, input int l1, input int l2,
                                input int l3, input int e);
        vec_t v;
        v.name = n;
        v.r[0] = 12'(r0); v.r[1] = 12'(r1); v.r[2] = 12'(r2); v.r[3] = 12'(r3);
        v.l[0] = 12'(l0); v.l[1] = 12'(l1); v.l[2] = 12'(l2); v.l[3] = 12'(l3);
        v.exp  = 10'(e);
        return v;
    endfunction

    task automatic drive(input logic [3:0][11:0] r, input logic [3:0][11:0] l);
        IR_R0 = r[0]; IR_R1 = r[1]; IR_R2 = r[2]; IR_R3 = r[3];
        IR_L0 = l[0]; IR_L1 = l[1]; IR_L2 = l[2]; IR_L3 = l[3];
    endtask

    task automatic drive_junk();
        IR_R0 = 12'hABC; IR_R1 = 12'h123; IR_R2 = 12'hFFF; IR_R3 = 12'hFFF;
        IR_L0 = 12'h777; IR_L1 = 12'h001; IR_L2 = 12'h0F0; IR_L3 = 12'h555;
    endtask

    // One frame at E0, then watch edges E1..E12 for latency, pulse count, busy span.
    task automatic run_frame(input vec_t v);
        int lat, pulses, busy_cnt;
        logic [9:0] got;
        lat = -1; pulses = 0; busy_cnt = 0; got = '0;
        @(negedge clk);
        drive(v.r, v.l);
        IR_vld = 1'b1;
        @(negedge clk);
        IR_vld = 1'b0;
        drive_junk();
        if (busy) busy_cnt++;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (err_vld) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    got = err_sat;
                end
            end
        end
        check({v.name, " value"}, 32'(got), 32'(v.exp));
        check({v.name, " latency"}, 32'(lat), 32'd9);
        check({v.name, " pulses"}, 32'(pulses), 32'd1);
        check({v.name, " busy_cycles"}, 32'(busy_cnt), 32'd9);
    endtask

    initial begin
        int edges[$];
        logic [9:0] vals[$];
        logic hold_ok;
        logic [9:0] hold_bad;
        int late_pulses;

        vecs[0]  = mk("zero",        0,   0,   0,     0,     0,     0,     0,     0,     10'h000);
        vecs[1]  = mk("r0_100",      100, 0,   0,     0,     0,     0,     0,     0,     10'h064);
        vecs[2]  = mk("r1_l2",       0,   300, 0,     0,     0,     0,     50,    0,     10'h190);
        vecs[3]  = mk("l3_32",       0,   0,   0,     0,     0,     0,     0,     32,    10'h300);
        vecs[4]  = mk("r3_max",      0,   0,   0,     4095,  0,     0,     0,     0,     10'h1FF);
        vecs[5]  = mk("all_l_max",   0,   0,   0,     0,     4095,  4095,  4095,  4095,  10'h200);
        vecs[6]  = mk("r3_63",       0,   0,   0,     63,    0,     0,     0,     0,     10'h1F8);
        vecs[7]  = mk("r0_511",      511, 0,   0,     0,     0,     0,     0,     0,     10'h1FF);
        vecs[8]  = mk("l0_512",      0,   0,   0,     0,     512,   0,     0,     0,     10'h200);
        vecs[9]  = mk("l0_513",      0,   0,   0,     0,     513,   0,     0,     0,     10'h200);
        vecs[10] = mk("mixed",       10,  5,   1,     1,     3,     2,     1,     2,     10'h005);

        rst_n  = 1'b0;
        IR_vld = 1'b0;
        drive_junk();
        repeat (3) @(negedge clk);
        check("reset err_sat", 32'(err_sat), 32'd0);
        check("reset err_vld", 32'(err_vld), 32'd0);
        check("reset busy",    32'(busy),    32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++)
            run_frame(vecs[i]);

        // err_sat must hold its last value while idle.
        run_frame(vecs[3]);
        hold_ok = 1'b1;
        hold_bad = '0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (err_sat !== 10'h300 || err_vld !== 1'b0 || busy !== 1'b0) begin
                hold_ok = 1'b0;
                hold_bad = err_sat;
            end
        end
        check("hold 50 idle", 32'(hold_ok), 32'd1);
        if (!hold_ok) $display("  err_sat seen 0x%0h", hold_bad);

        // Re-pulses at E3 and E9 ignored; pulse at E10 accepted.
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            if (k > 0 && err_vld) begin
                edges.push_back(k - 1);
                vals.push_back(err_sat);
            end
            drive_junk();
            IR_vld = 1'b0;
            if (k == 0) begin
                drive(vecs[1].r, vecs[1].l);
                IR_vld = 1'b1;
            end else if (k == 3 || k == 9) begin
                IR_vld = 1'b1;
            end else if (k == 10) begin
                drive(vecs[2].r, vecs[2].l);
                IR_vld = 1'b1;
            end
        end
        IR_vld = 1'b0;
        check("repulse count", 32'(edges.size()), 32'd2);
        if (edges.size() >= 2) begin
            check("repulse edge1", 32'(edges[0]), 32'd9);
            check("repulse val1",  32'(vals[0]),  32'h064);
            check("repulse edge2", 32'(edges[1]), 32'd19);
            check("repulse val2",  32'(vals[1]),  32'h190);
        end
        repeat (3) @(negedge clk);

        // Asynchronous reset between E4 and E5 abandons the frame.
        @(negedge clk);
        drive(vecs[1].r, vecs[1].l);
        IR_vld = 1'b1;
        @(negedge clk);
        IR_vld = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async err_sat", 32'(err_sat), 32'd0);
        check("async err_vld", 32'(err_vld), 32'd0);
        check("async busy",    32'(busy),    32'd0);
        #1;
        rst_n = 1'b1;
        late_pulses = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (err_vld || busy) late_pulses++;
        end
        check("no vld after reset", 32'(late_pulses), 32'd0);
        run_frame(vecs[10]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
